bcd_digit_streamer: RTL and testbench
=====================================

// Module: bcd_digit_streamer
// PURPOSE
//  Multi-digit BCD up/down counter with a digit-serial output port.
//  Sits directly upstream of the BCD-to-excess-3 converter.
//  On request, it snapshots the count and presents one 4-bit BCD digit at a time, LSD first.
//  Digits move over a valid/ready handshake, so the converter and later excess-3 stages see a clean digit stream.
// PARAMETERS
//  DIGITS  4  number of BCD digits in the counter (legal range 2..8)
// PORTS
//  clk       in   1         rising-edge clock; the only clock
//  rst_n     in   1         synchronous reset, active-low
//  en        in   1         count enable, one step per cycle
//  up        in   1         1 = count up, 0 = count down
//  load      in   1         load load_val into the counter
//  load_val  in   4*DIGITS  packed BCD load value; digit i = [4i+3:4i]
//  snap      in   1         request to stream the current count
//  cnt       out  4*DIGITS  registered packed BCD count
//  carry     out  1         one-cycle pulse on wrap (all 9 -> all 0 up; all 0 -> all 9 down)
//  load_err  out  1         one-cycle pulse when a load is rejected
//  busy      out  1         1 while state = SEND
//  d_valid   out  1         output digit valid
//  d_ready   in   1         downstream accepts the digit
//  d_digit   out  4         BCD digit; feeds converter inputs b3..b0
//  d_idx     out  clog2(DIGITS)  index of d_digit, 0 = LSD
//  d_last    out  1         d_digit is the MSD
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge), all outputs:
//   - cnt=0, carry=0, load_err=0, busy=0, d_valid=0, d_digit=0, d_idx=0, d_last=0
//   - state=IDLE; any stream in flight is dropped without completion
//  Counter priority, per cycle: load > en > hold.
//   - load=1 with every digit <=9: cnt <= load_val next cycle.
//   - load=1 with any digit >9: cnt unchanged, load_err=1 for 1 cycle, en ignored that cycle.
//  Count step (en=1, load=0):
//   - Up: digit 9 -> 0 and increments the next digit.
//   - Down: digit 0 -> 9 and decrements the next digit.
//   - Cascade is combinational within the same cycle; one step per cycle.
//   - carry=1 in the cycle after a full wrap; otherwise 0.
//  Counter runs independently of the streamer; counting continues while busy=1.
//  FSM states:
//   - IDLE: d_valid=0, busy=0. When snap=1:
//       - shadow <= cnt (pre-update value of that cycle)
//       - next state SEND, d_idx=0, d_valid=1 on the next cycle
//   - SEND: d_valid=1, busy=1.
//       - d_digit = shadow digit d_idx; d_last = (d_idx==DIGITS-1).
//       - d_digit, d_idx and d_last hold stable while d_valid=1 and d_ready=0.
//       - On d_valid&d_ready with d_last=0: d_idx+1 next cycle; d_valid stays 1, no bubble.
//       - On d_valid&d_ready with d_last=1: next state IDLE, d_valid=0, d_idx=0.
//  Handshake rules:
//   - d_valid never depends combinationally on d_ready.
//   - Acceptance takes 1 cycle per digit at full throughput.
//   - d_ready while d_valid=0 is ignored.
//  snap while busy=1 is ignored, including the cycle the MSD is accepted.
//   - A new snap is honoured from the first IDLE cycle.
//  Latency: snap at cycle N -> LSD valid at N+1.
//   - Full stream with d_ready held 1: DIGITS cycles; MSD accepted at N+DIGITS.
//  The shadow is never modified during SEND, so streamed digits are always a coherent snapshot.
//  Output digits are always BCD (0..9); the converter never sees 10..15.
// TESTING
//  1. Reset: rst_n=0 two cycles mid-stream -> all outputs 0, state IDLE; snap next cycle streams 0,0,0,0.
//  2. Up wrap: load 9999, en=1 up=1 -> cnt=0000, carry pulses 1 cycle; a second step gives 0001, carry=0.
//  3. Down borrow: load 1000, en=1 up=0 -> cnt=0999; from 0000 -> 9999 with carry pulse.
//  4. Bad load: load_val=0x12A4 -> load_err pulse, cnt unchanged, en ignored that cycle.
//  5. Stream 4721 with d_ready=1 -> d_digit 1,2,7,4 on consecutive cycles, d_idx 0..3, d_last only on 4;
//     counting during the stream does not change the output.
//  6. Backpressure: stream 0359, d_ready low 3 cycles on digit 5 -> digit stable, snap ignored while busy;
//     remaining digits 3,0 follow, then IDLE.

Source files
------------

// File: rtl/bcd_digit_streamer.sv
// Multi-digit BCD up/down counter with a digit-serial valid/ready output stream.
// A snap request captures the count into a shadow register and sends it out LSD first.
module bcd_digit_streamer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       up,
  input  logic                       load,
  input  logic [4*DIGITS-1:0]        load_val,
  input  logic                       snap,
  output logic [4*DIGITS-1:0]        cnt,
  output logic                       carry,
  output logic                       load_err,
  output logic                       busy,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [3:0]                 d_digit,
  output logic [$clog2(DIGITS)-1:0]  d_idx,
  output logic                       d_last
);

  localparam int unsigned IdxW = $clog2(DIGITS);

  typedef enum logic {StIdle, StSend} state_t;

  state_t                r_state;
  state_t                w_state_d;
  logic [4*DIGITS-1:0]   r_cnt;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [IdxW-1:0]       r_idx;
  logic [IdxW-1:0]       w_idx_d;
  logic                  r_carry;
  logic                  r_load_err;
  logic                  w_shadow_load;
  logic [4*DIGITS-1:0]   w_step;
  logic                  w_ripple;
  logic                  w_load_ok;
  logic                  w_last;

  // Ripple one step through the digits; w_ripple survives only if every digit wrapped.
  always_comb begin
    w_step   = r_cnt;
    w_ripple = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_ripple) begin
        if (up) begin
          if (r_cnt[4*i +: 4] == 4'd9) begin
            w_step[4*i +: 4] = 4'd0;
          end else begin
            w_step[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
            w_ripple         = 1'b0;
          end
        end else begin
          if (r_cnt[4*i +: 4] == 4'd0) begin
            w_step[4*i +: 4] = 4'd9;
          end else begin
            w_step[4*i +: 4] = r_cnt[4*i +: 4] - 4'd1;
            w_ripple         = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) w_load_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        if (w_load_ok) r_cnt <= load_val;
        else           r_load_err <= 1'b1;
      end else if (en) begin
        r_cnt   <= w_step;
        r_carry <= w_ripple;
      end
    end
  end

  assign w_last = (r_idx == IdxW'(DIGITS - 1));

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_shadow_load = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (snap) begin
          w_state_d     = StSend;
          w_idx_d       = '0;
          w_shadow_load = 1'b1;
        end
      end
      StSend: begin
        if (d_ready) begin
          if (w_last) begin
            w_state_d = StIdle;
            w_idx_d   = '0;
          end else begin
            w_idx_d = r_idx + IdxW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      if (w_shadow_load) r_shadow <= r_cnt;
    end
  end

  always_comb begin
    d_digit = 4'd0;
    if (r_state == StSend) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (r_idx == i[IdxW-1:0]) d_digit = r_shadow[4*i +: 4];
      end
    end
  end

  assign cnt      = r_cnt;
  assign carry    = r_carry;
  assign load_err = r_load_err;
  assign busy     = (r_state == StSend);
  assign d_valid  = (r_state == StSend);
  assign d_idx    = r_idx;
  assign d_last   = (r_state == StSend) && w_last;

endmodule

// File: tb/tb_bcd_digit_streamer.sv
// Scoreboard bench for bcd_digit_streamer: an integer-valued reference counter queues the
// expected digit stream on each snap; a negedge monitor checks every output against it.
module tb_bcd_digit_streamer;

  localparam int unsigned D   = 4;
  localparam int unsigned MOD = 10 ** D;

  logic             clk = 1'b0;
  logic             rst_n, en, up, load, snap, d_ready;
  logic [4*D-1:0]   load_val;
  logic [4*D-1:0]   cnt;
  logic             carry, load_err, busy, d_valid, d_last;
  logic [3:0]       d_digit;
  logic [$clog2(D)-1:0] d_idx;

  bcd_digit_streamer #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .snap(snap), .cnt(cnt), .carry(carry), .load_err(load_err), .busy(busy),
    .d_valid(d_valid), .d_ready(d_ready), .d_digit(d_digit), .d_idx(d_idx), .d_last(d_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned dig;
    int unsigned idx;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_val   = 0;
  int unsigned m_pend  = 0;
  bit          m_carry = 1'b0;
  bit          m_err   = 1'b0;
  bit          chk_en  = 1'b0;
  int          n_checks = 0;
  int          n_err    = 0;

  function automatic int unsigned digit_of(input int unsigned v, input int unsigned i);
    return (v / (10 ** i)) % 10;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < int'(D); i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic bit bcd_legal(input logic [4*D-1:0] v);
    for (int i = 0; i < int'(D); i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int unsigned from_bcd(input logic [4*D-1:0] v);
    int unsigned r = 0;
    for (int i = 0; i < int'(D); i++) r += int'(v[4*i +: 4]) * (10 ** i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the count is a plain integer modulo 10^D.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_val = 0; m_carry = 0; m_err = 0; m_pend = 0;
      exp_q.delete();
    end else begin
      bit was_busy;
      was_busy = (m_pend != 0);
      if (was_busy && d_ready) m_pend--;
      if (!was_busy && snap) begin
        for (int i = 0; i < int'(D); i++)
          exp_q.push_back('{dig: digit_of(m_val, i), idx: i, last: (i == int'(D) - 1)});
        m_pend = D;
      end
      m_carry = 0;
      m_err   = 0;
      if (load) begin
        if (bcd_legal(load_val)) m_val = from_bcd(load_val);
        else                     m_err = 1;
      end else if (en) begin
        if (up) begin
          m_carry = (m_val == MOD - 1);
          m_val   = (m_val + 1) % MOD;
        end else begin
          m_carry = (m_val == 0);
          m_val   = (m_val + MOD - 1) % MOD;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cnt", 32'(cnt), 32'(to_bcd(m_val)));
      chk("carry", 32'(carry), 32'(m_carry));
      chk("load_err", 32'(load_err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_pend != 0));
      chk("d_valid", 32'(d_valid), 32'(m_pend != 0));
      if (d_valid && exp_q.size() != 0) begin
        chk("d_digit", 32'(d_digit), exp_q[0].dig);
        chk("d_idx", 32'(d_idx), exp_q[0].idx);
        chk("d_last", 32'(d_last), 32'(exp_q[0].last));
        if (d_ready) void'(exp_q.pop_front());
      end else if (!d_valid) begin
        chk("idle_idx", 32'(d_idx), 32'd0);
        chk("idle_last", 32'(d_last), 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4*D-1:0] v);
    load = 1'b1; load_val = v;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; snap = 1'b0; d_ready = 1'b0;
    load_val = '0;
    step(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step(1);

    // Up wrap then one more step
    do_load(16'h9999);
    en = 1'b1; up = 1'b1;
    step(2);
    en = 1'b0;
    step(1);

    // Down borrow, then full down wrap
    do_load(16'h1000);
    en = 1'b1; up = 1'b0;
    step(1);
    en = 1'b0;
    do_load(16'h0000);
    en = 1'b1;
    step(1);
    en = 1'b0;
    step(1);

    // Rejected load with en asserted
    load = 1'b1; load_val = 16'h12A4; en = 1'b1; up = 1'b1;
    step(1);
    load = 1'b0; en = 1'b0;
    step(1);

    // Stream 4721 at full throughput while counting
    do_load(16'h4721);
    snap = 1'b1; d_ready = 1'b1;
    step(1);
    snap = 1'b0; en = 1'b1;
    step(4);
    en = 1'b0;
    step(2);

    // Backpressure on the second digit with snap held
    do_load(16'h0359);
    snap = 1'b1; d_ready = 1'b1;
    step(1);
    snap = 1'b0;
    step(1);
    d_ready = 1'b0; snap = 1'b1;
    step(3);
    snap = 1'b0; d_ready = 1'b1;
    step(4);

    // Reset mid-stream, then stream the cleared count
    do_load(16'h1234);
    snap = 1'b1; d_ready = 1'b0;
    step(1);
    snap = 1'b0;
    step(1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1; snap = 1'b1; d_ready = 1'b1;
    step(1);
    snap = 1'b0;
    step(5);

    // Random traffic
    repeat (3000) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      en      = $urandom_range(0, 1) == 1;
      up      = $urandom_range(0, 1) == 1;
      load    = ($urandom_range(0, 15) == 0);
      snap    = ($urandom_range(0, 3) == 0);
      d_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < int'(D); i++)
        load_val[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
      step(1);
    end

    rst_n = 1'b1; en = 1'b0; load = 1'b0; snap = 1'b0; d_ready = 1'b1;
    step(D + 2);
    chk("drain", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
